ycbcr2rgb: RTL and testbench
============================

# ycbcr2rgb

Pipelined BT.601 limited-range YCbCr-to-RGB888 converter. It is the inverse of the RGB-to-YCbCr front end and sits on the display side of the image pipeline, after any YCbCr-domain processing and before the video output encoder. The block has a fixed 4-cycle latency. Sync and enable signals are delayed by the same amount so that they stay aligned with the pixel data.

## Interface
Parameters (each coefficient is the real coefficient scaled by 256):
- COEF_Y, 298, Y gain (1.164)
- COEF_RV, 409, Cr contribution to R (1.596)
- COEF_GU, 100, Cb contribution to G, subtracted (0.392)
- COEF_GV, 208, Cr contribution to G, subtracted (0.813)
- COEF_BU, 516, Cb contribution to B (2.017)
- Y_OFFSET, 16, luma black level
- C_OFFSET, 128, chroma zero level

Ports:
- clk  in  1  pixel clock. One clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- ycbcr_y  in  8  luma
- ycbcr_cb  in  8  blue-difference chroma
- ycbcr_cr  in  8  red-difference chroma
- ycbcr_hs  in  1  hsync
- ycbcr_vs  in  1  vsync
- ycbcr_de  in  1  data enable
- rgb_r  out  8  red, registered
- rgb_g  out  8  green, registered
- rgb_b  out  8  blue, registered
- rgb_hs  out  1  delayed hsync, registered
- rgb_vs  out  1  delayed vsync, registered
- rgb_de  out  1  delayed data enable, registered

## Operation
Every cycle a new sample is accepted. There is no stall and no handshake. Data is converted regardless of ycbcr_de; downstream logic qualifies pixels with rgb_de.

Stage 1, offset removal (signed 10-bit):
- C = Y − Y_OFFSET
- D = Cb − C_OFFSET
- E = Cr − C_OFFSET
- Ranges: C is −16..239; D and E are −128..127.

Stage 2, multiplies (signed 19-bit products, all registered):
- yC = COEF_Y·C
- rE = COEF_RV·E
- gD = COEF_GU·D
- gE = COEF_GV·E
- bD = COEF_BU·D

Stage 3, sums with rounding (signed 20-bit accumulators, no overflow possible):
- sR = yC + rE + 128
- sG = yC − gD − gE + 128
- sB = yC + bD + 128

Stage 4, scale and clamp:
- Arithmetic right shift by 8, which floors toward −∞.
- Results below 0 become 0; results above 255 become 255; otherwise pass the low 8 bits.
- The clamped values are registered into rgb_r, rgb_g and rgb_b.

Sync path: ycbcr_hs, ycbcr_vs and ycbcr_de each pass through exactly 4 register stages. There is no tap skipping; all three signals see identical depth.

Reset:
- While rst is high, every pipeline register and every output is 0: rgb_r, rgb_g, rgb_b, rgb_hs, rgb_vs and rgb_de.
- Reset asserted mid-frame discards all in-flight samples immediately, without waiting for a clock edge.
- After rst deasserts, outputs show 0 / low until the first post-reset sample emerges 4 cycles later.

## Timing
- Latency: a sample presented at rising edge N appears on the outputs after rising edge N+4.
- Throughput: 1 sample per cycle, indefinitely.
- Alignment: rgb_r/g/b and rgb_hs/vs/de always belong to the same input cycle.
- Back-to-back samples never interact, since there is no accumulation across cycles.
- Clamping applies on every cycle, including blanking cycles.

## Test plan
- Black: Y=16, Cb=128, Cr=128 → R,G,B = 0,0,0.
- White: Y=235, Cb=128, Cr=128 → 255,255,255.
- Red: Y=81, Cb=90, Cr=240 → 255,0,0. This exercises the G floor of a small positive value and the B negative clamp.
- Upper clamp: Y=255, Cb=255, Cr=255 → 255,125,255. Lower clamp: Y=0, Cb=0, Cr=0 → 0,135,0.
- Latency and alignment:
  - Stimulus: a single-cycle ycbcr_de pulse carrying Y=235 (white), with hs high for 3 cycles and vs toggled, surrounded by Y=16 (black) samples.
  - Required response: rgb_de pulses exactly 4 cycles later, coincident with 255,255,255. hs and vs are shifted by exactly 4 cycles.
- Reset mid-stream:
  - Stimulus: stream a ramp Y=16..235 with de high, then assert rst asynchronously for 2 cycles.
  - Required response: all outputs go to 0 without waiting for a clock edge. After release, the first valid output is the first post-reset input, 4 cycles later; no pre-reset sample ever appears.

Source files
------------

// File: rtl/ycbcr2rgb.sv
// BT.601 limited-range YCbCr to RGB888 converter with a fixed 4-cycle pipeline.
// The hs/vs/de sideband signals travel through an equal-depth delay so they stay aligned with pixel data.
module ycbcr2rgb #(
    parameter int COEF_Y   = 298,
    parameter int COEF_RV  = 409,
    parameter int COEF_GU  = 100,
    parameter int COEF_GV  = 208,
    parameter int COEF_BU  = 516,
    parameter int Y_OFFSET = 16,
    parameter int C_OFFSET = 128
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] ycbcr_y,
    input  logic [7:0] ycbcr_cb,
    input  logic [7:0] ycbcr_cr,
    input  logic       ycbcr_hs,
    input  logic       ycbcr_vs,
    input  logic       ycbcr_de,
    output logic [7:0] rgb_r,
    output logic [7:0] rgb_g,
    output logic [7:0] rgb_b,
    output logic       rgb_hs,
    output logic       rgb_vs,
    output logic       rgb_de
);

    localparam logic signed [18:0] K_Y   = 19'(COEF_Y);
    localparam logic signed [18:0] K_RV  = 19'(COEF_RV);
    localparam logic signed [18:0] K_GU  = 19'(COEF_GU);
    localparam logic signed [18:0] K_GV  = 19'(COEF_GV);
    localparam logic signed [18:0] K_BU  = 19'(COEF_BU);
    localparam logic signed [9:0]  Y_OFF = 10'(Y_OFFSET);
    localparam logic signed [9:0]  C_OFF = 10'(C_OFFSET);

    logic signed [9:0]  c_s1, d_s1, e_s1;
    logic signed [18:0] c_x, d_x, e_x;
    logic signed [18:0] yc_s2, re_s2, gd_s2, ge_s2, bd_s2;
    logic signed [19:0] sr_s3, sg_s3, sb_s3;
    logic [2:0]         hs_d, vs_d, de_d;

    // Floor-shift by 8 then saturate to 0..255.
    function automatic logic [7:0] clamp8(input logic signed [19:0] s);
        logic signed [11:0] q;
        q = 12'(s >>> 8);
        if (q[11])
            clamp8 = '0;
        else if (|q[10:8])
            clamp8 = '1;
        else
            clamp8 = q[7:0];
    endfunction

    always_comb begin
        c_x = 19'(c_s1);
        d_x = 19'(d_s1);
        e_x = 19'(e_s1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_s1   <= '0;
            d_s1   <= '0;
            e_s1   <= '0;
            yc_s2  <= '0;
            re_s2  <= '0;
            gd_s2  <= '0;
            ge_s2  <= '0;
            bd_s2  <= '0;
            sr_s3  <= '0;
            sg_s3  <= '0;
            sb_s3  <= '0;
            rgb_r  <= '0;
            rgb_g  <= '0;
            rgb_b  <= '0;
            hs_d   <= '0;
            vs_d   <= '0;
            de_d   <= '0;
            rgb_hs <= 1'b0;
            rgb_vs <= 1'b0;
            rgb_de <= 1'b0;
        end else begin
            c_s1   <= $signed({2'b00, ycbcr_y})  - Y_OFF;
            d_s1   <= $signed({2'b00, ycbcr_cb}) - C_OFF;
            e_s1   <= $signed({2'b00, ycbcr_cr}) - C_OFF;

            yc_s2  <= c_x * K_Y;
            re_s2  <= e_x * K_RV;
            gd_s2  <= d_x * K_GU;
            ge_s2  <= e_x * K_GV;
            bd_s2  <= d_x * K_BU;

            sr_s3  <= 20'(yc_s2) + 20'(re_s2) + 20'sd128;
            sg_s3  <= 20'(yc_s2) - 20'(gd_s2) - 20'(ge_s2) + 20'sd128;
            sb_s3  <= 20'(yc_s2) + 20'(bd_s2) + 20'sd128;

            rgb_r  <= clamp8(sr_s3);
            rgb_g  <= clamp8(sg_s3);
            rgb_b  <= clamp8(sb_s3);

            hs_d   <= {hs_d[1:0], ycbcr_hs};
            vs_d   <= {vs_d[1:0], ycbcr_vs};
            de_d   <= {de_d[1:0], ycbcr_de};
            rgb_hs <= hs_d[2];
            rgb_vs <= vs_d[2];
            rgb_de <= de_d[2];
        end
    end

endmodule

// File: tb/tb_ycbcr2rgb.sv
// Directed self-checking bench for ycbcr2rgb: colour vectors, pipeline alignment and reset behaviour.
module tb_ycbcr2rgb;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] ycbcr_y, ycbcr_cb, ycbcr_cr;
    logic       ycbcr_hs, ycbcr_vs, ycbcr_de;
    logic [7:0] rgb_r, rgb_g, rgb_b;
    logic       rgb_hs, rgb_vs, rgb_de;

    int total = 0;
    int bad   = 0;

    ycbcr2rgb #(
        .COEF_Y  (298),
        .COEF_RV (409),
        .COEF_GU (100),
        .COEF_GV (208),
        .COEF_BU (516),
        .Y_OFFSET(16),
        .C_OFFSET(128)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ycbcr_y (ycbcr_y),
        .ycbcr_cb(ycbcr_cb),
        .ycbcr_cr(ycbcr_cr),
        .ycbcr_hs(ycbcr_hs),
        .ycbcr_vs(ycbcr_vs),
        .ycbcr_de(ycbcr_de),
        .rgb_r   (rgb_r),
        .rgb_g   (rgb_g),
        .rgb_b   (rgb_b),
        .rgb_hs  (rgb_hs),
        .rgb_vs  (rgb_vs),
        .rgb_de  (rgb_de)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] y, input logic [7:0] cb, input logic [7:0] cr,
                         input logic hs, input logic vs, input logic de);
        ycbcr_y  = y;
        ycbcr_cb = cb;
        ycbcr_cr = cr;
        ycbcr_hs = hs;
        ycbcr_vs = vs;
        ycbcr_de = de;
    endtask

    // Neutral-chroma reference: R = G = B = clamp((298*(Y-16)+128) >> 8).
    function automatic logic [7:0] gray(input int y);
        int v;
        v = (298 * (y - 16) + 128) >>> 8;
        if (v < 0) return 8'd0;
        if (v > 255) return 8'd255;
        return v[7:0];
    endfunction

    task automatic test_reset;
        logic [26:0] got;
        rst = 1'b1;
        drive(8'd200, 8'd50, 8'd60, 1'b1, 1'b1, 1'b1);
        repeat (3) tick();
        got = {rgb_r, rgb_g, rgb_b, rgb_hs, rgb_vs, rgb_de};
        total++;
        if (got !== 27'h0) begin
            bad++;
            $display("FAIL reset_hold: got=%h want=%h", got, 27'h0);
        end
        rst = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            got = {rgb_r, rgb_g, rgb_b, rgb_hs, rgb_vs, rgb_de};
            total++;
            if (i < 4 && got !== 27'h0) begin
                bad++;
                $display("FAIL reset_release_%0d: got=%h want=%h", i, got, 27'h0);
            end else if (i == 4 && got !== {8'd106, 8'd255, 8'd57, 3'b111}) begin
                bad++;
                $display("FAIL reset_first_out: got=%h want=%h", got, {8'd106, 8'd255, 8'd57, 3'b111});
            end
        end
    endtask

    task automatic test_colors;
        logic [7:0]  vy [5] = '{8'd16, 8'd235, 8'd81, 8'd255, 8'd0};
        logic [7:0]  vcb[5] = '{8'd128, 8'd128, 8'd90, 8'd255, 8'd0};
        logic [7:0]  vcr[5] = '{8'd128, 8'd128, 8'd240, 8'd255, 8'd0};
        logic [23:0] exp_rgb[5] = '{24'h000000, 24'hFFFFFF, 24'hFF0000, 24'hFF7DFF, 24'h008700};
        logic [23:0] got;
        for (int i = 0; i < 5; i++) begin
            drive(vy[i], vcb[i], vcr[i], 1'b0, 1'b0, 1'b1);
            repeat (4) tick();
            got = {rgb_r, rgb_g, rgb_b};
            total++;
            if (got !== exp_rgb[i]) begin
                bad++;
                $display("FAIL color_%0d: got=%h want=%h", i, got, exp_rgb[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0]  vy [7] = '{8'd16, 8'd235, 8'd81, 8'd255, 8'd0, 8'd200, 8'd126};
        logic [7:0]  vcb[7] = '{8'd128, 8'd128, 8'd90, 8'd255, 8'd0, 8'd50, 8'd128};
        logic [7:0]  vcr[7] = '{8'd128, 8'd128, 8'd240, 8'd255, 8'd0, 8'd60, 8'd128};
        logic [2:0]  vsy[7] = '{3'b001, 3'b100, 3'b011, 3'b110, 3'b001, 3'b101, 3'b010};
        logic [26:0] exp_out[7] = '{
            {24'h000000, 3'b001}, {24'hFFFFFF, 3'b100}, {24'hFF0000, 3'b011},
            {24'hFF7DFF, 3'b110}, {24'h008700, 3'b001}, {24'h6AFF39, 3'b101},
            {24'h808080, 3'b010}};
        logic [26:0] got;
        for (int i = 0; i < 10; i++) begin
            if (i < 7)
                drive(vy[i], vcb[i], vcr[i], vsy[i][2], vsy[i][1], vsy[i][0]);
            else
                drive(8'd16, 8'd128, 8'd128, 1'b0, 1'b0, 1'b0);
            tick();
            if (i >= 3) begin
                got = {rgb_r, rgb_g, rgb_b, rgb_hs, rgb_vs, rgb_de};
                total++;
                if (got !== exp_out[i-3]) begin
                    bad++;
                    $display("FAIL b2b_%0d: got=%h want=%h", i - 3, got, exp_out[i-3]);
                end
            end
        end
    endtask

    task automatic test_latency;
        logic [26:0] exp_out;
        logic [26:0] got;
        logic        hs_i, vs_i, de_i;
        logic [7:0]  vs_pat;
        vs_pat = 8'b0101_1010;
        for (int i = 0; i < 11; i++) begin
            if (i < 8) begin
                de_i = (i == 3);
                hs_i = (i >= 2 && i <= 4);
                vs_i = vs_pat[i];
                drive(de_i ? 8'd235 : 8'd16, 8'd128, 8'd128, hs_i, vs_i, de_i);
            end else begin
                drive(8'd16, 8'd128, 8'd128, 1'b0, 1'b0, 1'b0);
            end
            tick();
            if (i >= 3) begin
                de_i = (i - 3 == 3);
                hs_i = (i - 3 >= 2 && i - 3 <= 4);
                vs_i = vs_pat[i-3];
                exp_out = {de_i ? 24'hFFFFFF : 24'h000000, hs_i, vs_i, de_i};
                got = {rgb_r, rgb_g, rgb_b, rgb_hs, rgb_vs, rgb_de};
                total++;
                if (got !== exp_out) begin
                    bad++;
                    $display("FAIL latency_%0d: got=%h want=%h", i - 3, got, exp_out);
                end
            end
        end
    endtask

    task automatic test_reset_midstream;
        logic [26:0] exp_out;
        logic [26:0] got;
        for (int i = 0; i < 12; i++) begin
            drive(8'(16 + i), 8'd128, 8'd128, 1'b0, 1'b0, 1'b1);
            tick();
            if (i >= 3) begin
                exp_out = {gray(16 + i - 3), gray(16 + i - 3), gray(16 + i - 3), 3'b001};
                got = {rgb_r, rgb_g, rgb_b, rgb_hs, rgb_vs, rgb_de};
                total++;
                if (got !== exp_out) begin
                    bad++;
                    $display("FAIL ramp_%0d: got=%h want=%h", i - 3, got, exp_out);
                end
            end
        end
        drive(8'd28, 8'd128, 8'd128, 1'b1, 1'b1, 1'b1);
        #2 rst = 1'b1;
        #1;
        got = {rgb_r, rgb_g, rgb_b, rgb_hs, rgb_vs, rgb_de};
        total++;
        if (got !== 27'h0) begin
            bad++;
            $display("FAIL async_reset: got=%h want=%h", got, 27'h0);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            got = {rgb_r, rgb_g, rgb_b, rgb_hs, rgb_vs, rgb_de};
            total++;
            if (got !== 27'h0) begin
                bad++;
                $display("FAIL reset_held_%0d: got=%h want=%h", i, got, 27'h0);
            end
        end
        drive(8'd200, 8'd128, 8'd128, 1'b0, 1'b1, 1'b1);
        #2 rst = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            exp_out = (i < 4) ? 27'h0 : {gray(200), gray(200), gray(200), 3'b011};
            got = {rgb_r, rgb_g, rgb_b, rgb_hs, rgb_vs, rgb_de};
            total++;
            if (got !== exp_out) begin
                bad++;
                $display("FAIL post_reset_%0d: got=%h want=%h", i, got, exp_out);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
        test_reset();
        test_colors();
        test_back_to_back();
        test_latency();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
